instr_encoder: RTL and testbench

Streaming instruction encoder and program loader: accepts field-level instruction descriptions over a valid/ready handshake and packs them into 32-bit words in the core's instruction format. It writes those words sequentially into instruction memory through a registered write port with backpressure. It sits between the boot/debug host interface and the instruction-memory write port. It produces exactly the encoding that the core's decode stage consumes.

---
 rtl/instr_encoder_pkg.sv | 44 ++++
 rtl/instr_encoder_pack.sv | 54 +++++
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format definitions: format codes, field bit positions and opcodes.
// Used by the encoder, the packer and anything that needs to agree with the decode stage.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_RR = 2'd0,
        FMT_RI = 2'd1,
        FMT_CM = 2'd2,
        FMT_OP = 2'd3
    } fmt_e;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int SRC2_IMM_BIT = 26;
    localparam int RD_MSB       = 25;
    localparam int RD_LSB       = 22;
    localparam int COND_MSB     = 25;
    localparam int COND_LSB     = 22;
    localparam int RS_MSB       = 21;
    localparam int RS_LSB       = 18;
    localparam int RT_MSB       = 17;
    localparam int RT_LSB       = 14;
    localparam int IMM_MSB      = 17;
    localparam int IMM_LSB      = 0;
    localparam int MD_MSB       = 21;
    localparam int MD_LSB       = 0;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ALU  = 6'h04;
    localparam logic [5:0] OP_ALUI = 6'h05;
    localparam logic [5:0] OP_LD   = 6'h08;
    localparam logic [5:0] OP_ST   = 6'h0A;
    localparam logic [5:0] OP_BR   = 6'h10;
    localparam logic [5:0] OP_JMP  = 6'h12;
    localparam logic [5:0] OP_CALL = 6'h13;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // Running XOR signature over completed instruction words.
    function automatic logic [31:0] checksum_update(input logic [31:0] acc,
                                                    input logic [31:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: turns a field bundle into one 32-bit instruction word.
// Fields that do not belong to the selected format are left as zero.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    input  logic [3:0]  cond,
    input  logic [17:0] imm,
    input  logic [21:0] md,
    output logic [31:0] instr_word
);

    logic [31:0] word_s;

    // Place each field at its format-specific bit position.
    always_comb begin
        word_s = 32'h0000_0000;
        case (fmt)
            FMT_RR: begin
                word_s[OPCODE_MSB -: 5]    = opcode[5:1];
                word_s[SRC2_IMM_BIT]       = 1'b0;
                word_s[RD_MSB:RD_LSB]      = rd;
                word_s[RS_MSB:RS_LSB]      = rs;
                word_s[RT_MSB:RT_LSB]      = rt;
            end
            FMT_RI: begin
                word_s[OPCODE_MSB -: 5]    = opcode[5:1];
                word_s[SRC2_IMM_BIT]       = 1'b1;
                word_s[RD_MSB:RD_LSB]      = rd;
                word_s[RS_MSB:RS_LSB]      = rs;
                word_s[IMM_MSB:IMM_LSB]    = imm;
            end
            FMT_CM: begin
                // opcode[0] lands on the src2-immediate bit unchanged
                word_s[OPCODE_MSB:OPCODE_LSB] = opcode;
                word_s[COND_MSB:COND_LSB]     = cond;
                word_s[MD_MSB:MD_LSB]         = md;
            end
            FMT_OP: begin
                word_s[OPCODE_MSB:OPCODE_LSB] = opcode;
            end
            default: begin
                word_s = 32'h0000_0000;
            end
        endcase
    end

    assign instr_word = word_s;

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder / program loader: accepts field bundles, packs them and
// writes them sequentially into instruction memory through one registered write port.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_opcode,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic [3:0]        in_cond,
    input  logic [17:0]       in_imm,
    input  logic [21:0]       in_md,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic [31:0]       checksum,
    output logic              full
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    logic [31:0]       packed_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              handshake_s;

    logic              mem_we_r,        mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r,      mem_addr_nxt_s;
    logic [31:0]       mem_wdata_r,     mem_wdata_nxt_s;
    logic [ADDR_W:0]   words_written_r, words_written_nxt_s;
    logic [31:0]       checksum_r,      checksum_nxt_s;
    logic              full_r,          full_nxt_s;
    logic [ADDR_W:0]   accept_cnt_r,    accept_cnt_nxt_s;
    logic [ADDR_W-1:0] next_addr_r,     next_addr_nxt_s;

    instr_pack u_pack (
        .fmt        (in_fmt),
        .opcode     (in_opcode),
        .rd         (in_rd),
        .rs         (in_rs),
        .rt         (in_rt),
        .cond       (in_cond),
        .imm        (in_imm),
        .md         (in_md),
        .instr_word (packed_s)
    );

    // Accept only when the output register is free or draining this cycle; never while rewinding.
    always_comb begin
        in_ready_s  = ~full_r & (~mem_we_r | mem_ready) & ~restart & ~reset;
        accept_s    = in_valid & in_ready_s;
        handshake_s = mem_we_r & mem_ready;
    end

    // Next-state for the write port, session counters and signature.
    always_comb begin
        mem_we_nxt_s        = mem_we_r;
        mem_addr_nxt_s      = mem_addr_r;
        mem_wdata_nxt_s     = mem_wdata_r;
        words_written_nxt_s = words_written_r;
        checksum_nxt_s      = checksum_r;
        full_nxt_s          = full_r;
        accept_cnt_nxt_s    = accept_cnt_r;
        next_addr_nxt_s     = next_addr_r;

        if (restart) begin
            // A pending write is dropped without being counted.
            mem_we_nxt_s        = 1'b0;
            mem_addr_nxt_s      = BASE_A;
            mem_wdata_nxt_s     = 32'h0000_0000;
            words_written_nxt_s = '0;
            checksum_nxt_s      = 32'h0000_0000;
            full_nxt_s          = 1'b0;
            accept_cnt_nxt_s    = '0;
            next_addr_nxt_s     = BASE_A;
        end else begin
            if (handshake_s) begin
                words_written_nxt_s = words_written_r + ONE_C;
                checksum_nxt_s      = checksum_update(checksum_r, mem_wdata_r);
            end else begin
                words_written_nxt_s = words_written_r;
                checksum_nxt_s      = checksum_r;
            end

            if (accept_s) begin
                mem_we_nxt_s     = 1'b1;
                mem_addr_nxt_s   = next_addr_r;
                mem_wdata_nxt_s  = packed_s;
                next_addr_nxt_s  = next_addr_r + ONE_A;
                accept_cnt_nxt_s = accept_cnt_r + ONE_C;
                full_nxt_s       = ((accept_cnt_r + ONE_C) == DEPTH_C);
            end else if (handshake_s) begin
                mem_we_nxt_s = 1'b0;
            end else begin
                mem_we_nxt_s = mem_we_r;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_r        <= 1'b0;
            mem_addr_r      <= BASE_A;
            mem_wdata_r     <= 32'h0000_0000;
            words_written_r <= '0;
            checksum_r      <= 32'h0000_0000;
            full_r          <= 1'b0;
            accept_cnt_r    <= '0;
            next_addr_r     <= BASE_A;
        end else begin
            mem_we_r        <= mem_we_nxt_s;
            mem_addr_r      <= mem_addr_nxt_s;
            mem_wdata_r     <= mem_wdata_nxt_s;
            words_written_r <= words_written_nxt_s;
            checksum_r      <= checksum_nxt_s;
            full_r          <= full_nxt_s;
            accept_cnt_r    <= accept_cnt_nxt_s;
            next_addr_r     <= next_addr_nxt_s;
        end
    end

    assign in_ready      = in_ready_s;
    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign words_written = words_written_r;
    assign checksum      = checksum_r;
    assign full          = full_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven bundles, scoreboard on the write port,
// plus hand-written backpressure, full/wrap, restart and reset sequences.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 14;
    localparam int DEPTH     = 4;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  opcode;
        logic [3:0]  rd, rs, rt, cond;
        logic [17:0] imm;
        logic [21:0] md;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset, restart, in_valid, in_ready, mem_we, mem_ready, full;
    logic [1:0]        in_fmt;
    logic [5:0]        in_opcode;
    logic [3:0]        in_rd, in_rs, in_rt, in_cond;
    logic [17:0]       in_imm;
    logic [21:0]       in_md;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, checksum;
    logic [ADDR_W:0]   words_written;

    int   n_total = 0;
    int   n_pass  = 0;
    int   acc_idx = 0;
    exp_t sb_q[$];
    logic [31:0] exp_cs = 32'h0;
    int   exp_ww = 0;
    vec_t tbl[8];
    vec_t bp[4];

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs),
        .in_rt(in_rt), .in_cond(in_cond), .in_imm(in_imm), .in_md(in_md),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .words_written(words_written),
        .checksum(checksum), .full(full)
    );

    always #5 clk = ~clk;

    // Reference encoding written straight from the instruction format.
    function automatic logic [31:0] ref_word(input vec_t v);
        logic [5:0] op;
        op = v.opcode;
        case (v.fmt)
            2'd0:    return {op[5:1], 1'b0, v.rd, v.rs, v.rt, 14'h0};
            2'd1:    return {op[5:1], 1'b1, v.rd, v.rs, v.imm};
            2'd2:    return {op, v.cond, v.md};
            default: return {op, 26'h0};
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] f, input logic [5:0] op,
                                input logic [3:0] rd, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [3:0] cond,
                                input logic [17:0] imm, input logic [21:0] md);
        vec_t v;
        v.fmt = f; v.opcode = op; v.rd = rd; v.rs = rs; v.rt = rt;
        v.cond = cond; v.imm = imm; v.md = md;
        v.exp = ref_word(v);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard: a write that will complete at the next edge is popped and compared.
    always @(negedge clk) begin
        if (reset || restart) begin
            sb_q.delete();
            exp_cs = 32'h0;
            exp_ww = 0;
        end else if (mem_we && mem_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got write to %h, expected none", mem_addr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_addr", 32'(mem_addr), 32'(e.addr));
                check("sb_data", mem_wdata, e.word);
                exp_cs = exp_cs ^ e.word;
                exp_ww++;
            end
        end
    end

    task automatic set_fields(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.opcode; in_rd = v.rd; in_rs = v.rs;
        in_rt = v.rt; in_cond = v.cond; in_imm = v.imm; in_md = v.md;
    endtask

    task automatic send(input vec_t v, input int budget);
        bit got;
        exp_t e;
        got = 1'b0;
        set_fields(v);
        in_valid = 1'b1;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.addr = ADDR_W'((BASE_ADDR + acc_idx) % (1 << ADDR_W));
                e.word = v.exp;
                sb_q.push_back(e);
                acc_idx++;
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL send_timeout: got no accept, expected accept within %0d cycles", budget);
        end
    endtask

    task automatic do_restart();
        in_valid = 1'b0;
        restart  = 1'b1;
        @(posedge clk); #1;
        restart  = 1'b0;
        acc_idx  = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},   32'(mem_we), 32'h0);
        check({tag, "_addr"}, 32'(mem_addr), 32'(BASE_ADDR));
        check({tag, "_data"}, mem_wdata, 32'h0);
        check({tag, "_ww"},   32'(words_written), 32'h0);
        check({tag, "_cs"},   checksum, 32'h0);
        check({tag, "_full"}, 32'(full), 32'h0);
    endtask

    initial begin
        logic [31:0] bp_cs;
        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        set_fields(mk(2'd0, OP_NOP, 4'h0, 4'h0, 4'h0, 4'h0, 18'h0, 22'h0));

        tbl[0] = mk(2'd0, OP_ALU,  4'h3, 4'h5, 4'h7, 4'h9, 18'h00000, 22'h000000);
        tbl[1] = mk(2'd0, OP_ALU,  4'h3, 4'h5, 4'h7, 4'hF, 18'h3FFFF, 22'h3FFFFF);
        tbl[2] = mk(2'd1, OP_ALU,  4'h3, 4'h5, 4'h7, 4'h0, 18'h3FFFF, 22'h000000);
        tbl[3] = mk(2'd1, OP_ALUI, 4'hF, 4'h0, 4'hC, 4'h6, 18'h12345, 22'h155555);
        tbl[4] = mk(2'd2, OP_BR,   4'h1, 4'h2, 4'h3, 4'hA, 18'h3FFFF, 22'h2AAAAA);
        tbl[5] = mk(2'd2, OP_CALL, 4'h0, 4'h0, 4'h0, 4'h5, 18'h00000, 22'h3FFFFF);
        tbl[6] = mk(2'd3, OP_HALT, 4'hF, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 22'h3FFFFF);
        tbl[7] = mk(2'd3, OP_NOP,  4'hA, 4'h5, 4'hA, 4'h5, 18'h2AAAA, 22'h155555);
        bp[0]  = mk(2'd2, OP_JMP,  4'h0, 4'h0, 4'h0, 4'h1, 18'h0, 22'h000001);
        bp[1]  = mk(2'd2, OP_CALL, 4'h0, 4'h0, 4'h0, 4'h2, 18'h0, 22'h0ABCDE);
        bp[2]  = mk(2'd2, OP_BR,   4'h0, 4'h0, 4'h0, 4'h3, 18'h0, 22'h300000);
        bp[3]  = mk(2'd2, OP_LD,   4'h0, 4'h0, 4'h0, 4'h4, 18'h0, 22'h054321);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        check("ready_after_reset", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        // RR example with a hand-derived word, one-cycle latency
        send(tbl[0], 4);
        @(negedge clk);
        check("rr_we", 32'(mem_we), 32'h1);
        check("rr_addr", 32'(mem_addr), 32'(BASE_ADDR));
        check("rr_data", mem_wdata, 32'h10D5_C000);
        @(posedge clk); #1;

        // Table: two full sessions, back to back, wrapping 14,15,0,1
        for (int g = 0; g < 2; g++) begin
            do_restart();
            for (int k = 0; k < 4; k++) send(tbl[g * 4 + k], 4);
            repeat (3) @(posedge clk);
            #1;
            @(negedge clk);
            check("tbl_ww", 32'(words_written), 32'(exp_ww));
            check("tbl_ww4", 32'(words_written), 32'd4);
            check("tbl_cs", checksum, exp_cs);
            check("tbl_full", 32'(full), 32'h1);
            @(posedge clk); #1;
        end

        // Backpressure mid-stream: held port, no accept, then drain
        do_restart();
        send(bp[0], 4);
        send(bp[1], 4);
        mem_ready = 1'b0;
        set_fields(bp[2]);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready", 32'(in_ready), 32'h0);
            check("bp_we", 32'(mem_we), 32'h1);
            check("bp_addr", 32'(mem_addr), 32'((BASE_ADDR + 1) % (1 << ADDR_W)));
            check("bp_data", mem_wdata, bp[1].exp);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        send(bp[2], 4);
        send(bp[3], 4);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        bp_cs = bp[0].exp ^ bp[1].exp ^ bp[2].exp ^ bp[3].exp;
        check("bp_ww", 32'(words_written), 32'd4);
        check("bp_cs", checksum, bp_cs);
        check("bp_q_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;

        // Full: 4 accepts, a fifth bundle refused
        do_restart();
        for (int k = 0; k < 4; k++) send(tbl[k + 4], 4);
        @(negedge clk);
        check("full_set", 32'(full), 32'h1);
        check("full_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        set_fields(tbl[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("fifth_refused", 32'(in_ready), 32'h0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_ww", 32'(words_written), 32'd4);
        check("full_held", 32'(full), 32'h1);
        check("full_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;

        // Restart while a write is stalled
        do_restart();
        send(tbl[3], 4);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        restart = 1'b1;
        @(negedge clk);
        check("rs_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        restart = 1'b0;
        acc_idx = 0;
        @(negedge clk);
        check("rs_we", 32'(mem_we), 32'h0);
        check("rs_ww", 32'(words_written), 32'h0);
        check("rs_cs", checksum, 32'h0);
        check("rs_full", 32'(full), 32'h0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        send(tbl[5], 4);
        @(negedge clk);
        check("rs_next_addr", 32'(mem_addr), 32'(BASE_ADDR));
        check("rs_next_data", mem_wdata, tbl[5].exp);
        @(posedge clk); #1;

        // Reset mid-stream
        send(tbl[6], 4);
        mem_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst2_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        acc_idx = 0;
        mem_ready = 1'b1;
        @(negedge clk);
        check_reset_vals("rst2");
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
